mw93_responder: RTL
===================

// Module: mw93_responder
// PURPOSE
// Microwire (93xx-style) serial EEPROM responder: the device end of the 3-wire bus.
// It samples CS/SK/DI with the system clock and decodes start bit, opcode and
// address, then services READ/WRITE/ERASE/EWEN/EWDS/ERAL/WRAL against an internal
// 2^ADDR_W x DATA_W array. It is the target that the board's Microwire host sequencer
// talks to, and it replaces the physical EEPROM in sim and FPGA builds.
// PARAMETERS
// ADDR_W     6    address bits per command (64 words)
// DATA_W     16   word width, shifted MSB first
// BUSY_CYC   32   clk cycles of self-timed program for WRITE/ERASE (>=1)
// PORTS
// clk        in   1       system clock; must run at least 8x SK
// rst        in   1       asynchronous reset, active-high
// cs_i       in   1       Microwire chip select, active-high, async to clk
// sk_i       in   1       Microwire serial clock, async to clk
// di_i       in   1       serial data in
// do_o       out  1       serial data out
// do_oe      out  1       output enable for do_o (tri-state at pad)
// busy_o     out  1       self-timed program cycle in progress
// BEHAVIOUR
// - cs/sk/di go through 2-flop synchronisers. sk_rise is registered sk 0->1; cs_fall is cs 1->0.
// - Reset: state=IDLE, do_o=1, do_oe=0, busy_o=0, wen=0 (writes disabled), counters 0.
//   The array is not reset. A reset during BUSY abandons the program cycle; that
//   word keeps its old value (ERAL/WRAL: words already written stay written).
// - Sync cs low (outside BUSY): return to IDLE the same cycle, do_oe=0. A partial command is discarded.
// - States: IDLE -> START -> OPC -> ADR -> {RD | WD | EXEC} -> BUSY -> IDLE.
//   START: while cs high, each sk_rise samples di. Leading 0s are ignored. A 1 goes to OPC.
//   OPC: 2 bits. ADR: ADDR_W bits, MSB first. Decode on the last ADR sk_rise:
//     10 READ -> RD; 01 WRITE -> WD; 11 ERASE -> EXEC;
//     00 with addr[MSB:MSB-1]: 11 EWEN, 00 EWDS (set/clear wen, go to EXEC, no BUSY),
//     10 ERAL -> EXEC, 01 WRAL -> WD.
//   RD: do_oe=1. The cycle after decode, do_o=0 (dummy bit). Each following sk_rise
//     drives the next data bit MSB-first, 1 clk after detection. After DATA_W bits the
//     address increments (wraps 2^ADDR_W-1 -> 0) and streaming continues while cs is high.
//   WD: shift DATA_W bits in on sk_rise, then go to EXEC. Extra sk_rise is ignored.
//   EXEC: wait for cs_fall. If wen=0, or a program op has an incomplete data word,
//     go to IDLE with no write. Otherwise go to BUSY.
//   BUSY: busy_o=1 for BUSY_CYC clks. ERASE writes all ones. WRITE writes the data.
//     ERAL/WRAL write all words, one per clk from addr 0, and stretch BUSY to
//     max(BUSY_CYC, 2^ADDR_W). Single-word commit happens on the final BUSY clk.
//     cs/sk are ignored for command purposes. If cs goes high during BUSY: do_oe=1, do_o=0.
//   End of BUSY: busy_o=0. If cs is high: do_o=1 (ready) and hold until cs_fall, then IDLE.
//     If cs is low: IDLE.
// - sk_rise and cs_fall in the same clk: cs_fall wins, and that sk_rise is discarded.
// - wen survives everything except rst and EWDS.
// TESTING
// - rst asserted mid-READ -> do_oe=0, busy_o=0, wen=0 next clk. Then WRITE addr 5 =0x1234
//   -> no BUSY, and a READ of 5 returns the old value.
// - EWEN (1 00 11xxxx), WRITE addr 0x2A data 0xA5C3 -> busy_o high for 32 clk after cs_fall.
//   cs high during BUSY shows do_o=0, then 1. READ 0x2A -> 0, then 0xA5C3 MSB-first.
// - Sequential READ from 0x3F with cs held for 33 sk -> dummy 0, word[0x3F], then word[0x00].
// - ERASE addr 3 then WRAL 0x0F0F with wen=1 -> BUSY >= 64 clk. READ 3 and 0x3F -> 0x0F0F.
// - Three leading 0s before start, and cs dropped after 4 address bits -> the first is
//   ignored, the second aborts with no array change and returns to IDLE.
// - EWDS then ERAL -> no BUSY, contents unchanged.

Source files
------------

// File: rtl/mw93_responder.sv
`default_nettype none
// ============================================================================
// Module      : mw93_responder
// Description : Device end of a 3-wire Microwire (93xx-style) serial EEPROM.
//               CS/SK/DI are synchronised to clk. The block decodes start bit,
//               opcode and address, then services READ/WRITE/ERASE/EWEN/EWDS/
//               ERAL/WRAL against an internal 2^ADDR_W x DATA_W array.
// Ports       : clk     system clock, at least 8x SK
//               rst     asynchronous reset, active-high
//               cs_i    chip select (async to clk)
//               sk_i    serial clock (async to clk)
//               di_i    serial data in
//               do_o    serial data out
//               do_oe   output enable for do_o
//               busy_o  self-timed program cycle in progress
// Revision    : 1.0  initial release
// ============================================================================
module mw93_responder #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 16,
    parameter int BUSY_CYC = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_i,
    input  logic sk_i,
    input  logic di_i,
    output logic do_o,
    output logic do_oe,
    output logic busy_o
);

    localparam int c_DEPTH    = 2 ** ADDR_W;
    localparam int c_CNT_MAX  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int c_BIT_W    = $clog2(c_CNT_MAX);
    localparam int c_BUSY_ALL = (BUSY_CYC > c_DEPTH) ? BUSY_CYC : c_DEPTH;
    localparam int c_BUSY_W   = $clog2(c_BUSY_ALL) + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_OPC, S_ADR, S_RD, S_WD, S_EXEC, S_BUSY, S_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    // Synchronisers and edge detect
    logic r_cs_meta, r_cs_sync, r_cs_prev;
    logic r_sk_meta, r_sk_sync, r_sk_prev;
    logic r_di_meta, r_di_sync;

    // Command / datapath registers
    logic [c_BIT_W-1:0]  r_bit_cnt;
    logic [1:0]          r_opc;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_wen;
    logic                r_prog;     // command needs a program cycle
    logic                r_all;      // program cycle covers every word
    logic [c_BUSY_W-1:0] r_busy_cnt;
    logic                r_do;
    logic [DATA_W-1:0]   r_mem [0:c_DEPTH-1];

    logic                w_sk_rise;
    logic [ADDR_W-1:0]   w_addr_full;
    logic [ADDR_W-1:0]   w_addr_inc;
    logic                w_last_adr;
    logic                w_last_wd;
    logic                w_busy_last;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_waddr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cs_meta <= 1'b0; r_cs_sync <= 1'b0; r_cs_prev <= 1'b0;
            r_sk_meta <= 1'b0; r_sk_sync <= 1'b0; r_sk_prev <= 1'b0;
            r_di_meta <= 1'b0; r_di_sync <= 1'b0;
        end else begin
            r_cs_meta <= cs_i; r_cs_sync <= r_cs_meta; r_cs_prev <= r_cs_sync;
            r_sk_meta <= sk_i; r_sk_sync <= r_sk_meta; r_sk_prev <= r_sk_sync;
            r_di_meta <= di_i; r_di_sync <= r_di_meta;
        end
    end

    // An SK edge coinciding with CS going low is dropped: CS low wins.
    assign w_sk_rise   = r_sk_sync & ~r_sk_prev & r_cs_sync;
    assign w_addr_full = {r_addr[ADDR_W-2:0], r_di_sync};
    assign w_addr_inc  = r_addr + ADDR_W'(1);
    assign w_last_adr  = (r_state == S_ADR) && w_sk_rise && (r_bit_cnt == c_BIT_W'(ADDR_W - 1));
    assign w_last_wd   = (r_state == S_WD)  && w_sk_rise && (r_bit_cnt == c_BIT_W'(DATA_W - 1));
    assign w_busy_last = r_all ? (r_busy_cnt == c_BUSY_W'(c_BUSY_ALL - 1))
                               : (r_busy_cnt == c_BUSY_W'(BUSY_CYC - 1));
    assign do_o        = r_do;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy_o      = (r_state == S_BUSY);
        do_oe       = r_cs_sync && ((r_state == S_RD) || (r_state == S_BUSY) || (r_state == S_DONE));
        case (r_state)
            S_IDLE:  if (r_cs_sync) w_state_nxt = S_START;
            S_START: if (w_sk_rise && r_di_sync) w_state_nxt = S_OPC;
            S_OPC:   if (w_sk_rise && (r_bit_cnt == c_BIT_W'(1))) w_state_nxt = S_ADR;
            S_ADR: begin
                if (w_last_adr) begin
                    case (r_opc)
                        2'b10:   w_state_nxt = S_RD;
                        2'b01:   w_state_nxt = S_WD;
                        2'b11:   w_state_nxt = S_EXEC;
                        default: w_state_nxt = (w_addr_full[ADDR_W-1 -: 2] == 2'b01) ? S_WD : S_EXEC;
                    endcase
                end
            end
            S_RD:    w_state_nxt = S_RD;
            S_WD:    if (w_last_wd) w_state_nxt = S_EXEC;
            S_EXEC:  if (!r_cs_sync) w_state_nxt = (r_prog && r_wen) ? S_BUSY : S_IDLE;
            S_BUSY:  if (w_busy_last) w_state_nxt = r_cs_sync ? S_DONE : S_IDLE;
            S_DONE:  if (!r_cs_sync) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // CS low discards any partially shifted command or read stream.
        if (!r_cs_sync && ((r_state == S_START) || (r_state == S_OPC) || (r_state == S_ADR) ||
                           (r_state == S_RD) || (r_state == S_WD)))
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt  <= '0;
            r_opc      <= 2'b00;
            r_addr     <= '0;
            r_data     <= '0;
            r_wen      <= 1'b0;
            r_prog     <= 1'b0;
            r_all      <= 1'b0;
            r_busy_cnt <= '0;
            r_do       <= 1'b1;
        end else begin
            if (w_state_nxt == S_IDLE) r_do <= 1'b1;
            case (r_state)
                S_START: if (w_sk_rise && r_di_sync) r_bit_cnt <= '0;
                S_OPC: begin
                    if (w_sk_rise) begin
                        r_opc     <= {r_opc[0], r_di_sync};
                        r_bit_cnt <= (r_bit_cnt == c_BIT_W'(1)) ? '0 : r_bit_cnt + c_BIT_W'(1);
                    end
                end
                S_ADR: begin
                    if (w_sk_rise) begin
                        r_addr    <= w_addr_full;
                        r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                    end
                    if (w_last_adr) begin
                        r_bit_cnt <= '0;
                        r_prog    <= 1'b0;
                        r_all     <= 1'b0;
                        case (r_opc)
                            2'b10: begin
                                r_data <= r_mem[w_addr_full];
                                r_do   <= 1'b0;           // dummy bit ahead of data
                            end
                            2'b01: r_prog <= 1'b1;
                            2'b11: begin
                                r_prog <= 1'b1;
                                r_data <= '1;
                            end
                            default: begin
                                case (w_addr_full[ADDR_W-1 -: 2])
                                    2'b11: r_wen <= 1'b1;
                                    2'b00: r_wen <= 1'b0;
                                    2'b10: begin
                                        r_prog <= 1'b1;
                                        r_all  <= 1'b1;
                                        r_data <= '1;
                                    end
                                    default: begin
                                        r_prog <= 1'b1;
                                        r_all  <= 1'b1;
                                    end
                                endcase
                            end
                        endcase
                    end
                end
                S_RD: begin
                    if (w_sk_rise) begin
                        r_do <= r_data[DATA_W-1];
                        if (r_bit_cnt == c_BIT_W'(DATA_W - 1)) begin
                            // Word done: preload the next word so streaming is seamless.
                            r_bit_cnt <= '0;
                            r_addr    <= w_addr_inc;
                            r_data    <= r_mem[w_addr_inc];
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
                            r_data    <= {r_data[DATA_W-2:0], 1'b0};
                        end
                    end
                end
                S_WD: begin
                    if (w_sk_rise) begin
                        r_data    <= {r_data[DATA_W-2:0], r_di_sync};
                        r_bit_cnt <= w_last_wd ? '0 : r_bit_cnt + c_BIT_W'(1);
                    end
                end
                S_EXEC: begin
                    if (w_state_nxt == S_BUSY) begin
                        r_busy_cnt <= '0;
                        r_do       <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_busy_cnt <= r_busy_cnt + c_BUSY_W'(1);
                    if (w_busy_last && r_cs_sync) r_do <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Bulk ops sweep one word per clk from address 0; single-word ops
    // commit only on the final busy clk so an aborted cycle leaves it intact.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_waddr = r_addr;
        if (r_state == S_BUSY) begin
            if (r_all) begin
                w_mem_we    = (r_busy_cnt < c_BUSY_W'(c_DEPTH));
                w_mem_waddr = r_busy_cnt[ADDR_W-1:0];
            end else begin
                w_mem_we    = w_busy_last;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= r_data;
    end

endmodule
`default_nettype wire
